// File: rtl/operand_forward_ctrl.sv
// Load-use hazard detection and EX operand forwarding selects for a
// 4-stage pipeline (ID, EX, MEM, WB). Tracks in-flight destinations.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   id_valid                  : ID holds a valid instruction
//   id_rs1, id_rs2            : source register indices
//   id_rs1_used, id_rs2_used  : source actually read
//   id_rd, id_wen, id_load    : destination, writes rd, is a load
//   flush                     : kill the instruction in ID
//   stall                     : hold PC/IF/ID (combinational)
//   fwd_sel_a, fwd_sel_b      : EX operand mux4 selects (registered)
//   ex_valid                  : EX holds a non-bubble instruction
//   stall_count               : saturating count of stall cycles
module operand_forward_ctrl #(
  parameter int REGADDR = 4,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REGADDR-1:0] id_rs1,
  input  logic [REGADDR-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REGADDR-1:0] id_rd,
  input  logic               id_wen,
  input  logic               id_load,
  input  logic               flush,
  output logic               stall,
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
  output logic               ex_valid,
  output logic [CNTW-1:0]    stall_count
);

  typedef struct packed {
    logic               valid;
    logic [REGADDR-1:0] rd;
    logic               wen;
    logic               load;
  } shad_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  shad_t             r_ex;
  shad_t             r_mem;
  shad_t             r_wb;
  logic [1:0]        r_sel_a;
  logic [1:0]        r_sel_b;
  logic [CNTW-1:0]   r_cnt;

  logic              w_ex_prod;
  logic              w_mem_prod;
  logic              w_wb_prod;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_stall;
  logic              w_take;
  shad_t             w_id;
  logic [1:0]        w_sel_a;
  logic [1:0]        w_sel_b;

  // r0 is hardwired zero, so a write to it never produces a value.
  assign w_ex_prod  = r_ex.valid  & r_ex.wen  & (r_ex.rd  != '0);
  assign w_mem_prod = r_mem.valid & r_mem.wen & (r_mem.rd != '0);
  assign w_wb_prod  = r_wb.valid  & r_wb.wen  & (r_wb.rd  != '0);

  assign w_hit1 = id_rs1_used & (id_rs1 == r_ex.rd);
  assign w_hit2 = id_rs2_used & (id_rs2 == r_ex.rd);

  // Load data is not ready until MEM/WB, so an EX-stage load
  // consumer must wait one cycle. A flush wins over the stall.
  assign w_stall = ~flush & id_valid & w_ex_prod & r_ex.load
                 & (w_hit1 | w_hit2);

  assign w_take = id_valid & ~w_stall & ~flush;

  assign w_id.valid = 1'b1;
  assign w_id.rd    = id_rd;
  assign w_id.wen   = id_wen;
  assign w_id.load  = id_load;

  // Youngest producer first; the shadow stages are one step older
  // than they will be once this instruction reaches EX.
  function automatic logic [1:0] sel_f(
    input logic               used,
    input logic [REGADDR-1:0] s,
    input logic               ex_p,
    input logic [REGADDR-1:0] ex_rd,
    input logic               mem_p,
    input logic [REGADDR-1:0] mem_rd,
    input logic               wb_p,
    input logic [REGADDR-1:0] wb_rd
  );
    logic [1:0] v;
    v = SEL_RF;
    if (used && s != '0) begin
      if (ex_p && s == ex_rd)        v = SEL_EX;
      else if (mem_p && s == mem_rd) v = SEL_MEM;
      else if (wb_p && s == wb_rd)   v = SEL_WB;
    end
    return v;
  endfunction

  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (w_take) begin
      w_sel_a = sel_f(id_rs1_used, id_rs1,
                      w_ex_prod, r_ex.rd,
                      w_mem_prod, r_mem.rd,
                      w_wb_prod, r_wb.rd);
      w_sel_b = sel_f(id_rs2_used, id_rs2,
                      w_ex_prod, r_ex.rd,
                      w_mem_prod, r_mem.rd,
                      w_wb_prod, r_wb.rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else begin
      r_mem   <= r_ex;
      r_wb    <= r_mem;
      r_ex    <= w_take ? w_id : '0;
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_stall && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign stall       = w_stall;
  assign fwd_sel_a   = r_sel_a;
  assign fwd_sel_b   = r_sel_b;
  assign ex_valid    = r_ex.valid;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl: forwarding distances,
// load-use stall, flush, r0/unused sources, saturation, async reset.
module tb_operand_forward_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [3:0] id_rd;
  logic       id_wen;
  logic       id_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       ex_valid;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  operand_forward_ctrl #(.REGADDR(4), .CNTW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_load     (id_load),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .ex_valid    (ex_valid),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic u1,
                     input logic u2, input logic [3:0] rd,
                     input logic wen, input logic ld,
                     input logic fl);
    @(negedge clk);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = rd;
    id_wen      = wen;
    id_load     = ld;
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU op rd <- rs1, rs2, both sources used
  task automatic alu(input logic [3:0] rd, input logic [3:0] a,
                     input logic [3:0] b);
    drv(1'b1, a, b, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = '0; id_wen = 1'b0; id_load = 1'b0; flush = 1'b0;
    #2;
    chk("rst_sel_a", fwd_sel_a, 0);
    chk("rst_sel_b", fwd_sel_b, 0);
    chk("rst_exv", ex_valid, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first instruction sees no producers
    alu(4'd1, 4'd2, 4'd3);
    chk("t1_stall", stall, 0);
    tick();
    chk("t1_exv", ex_valid, 1);
    chk("t1_sa", fwd_sel_a, 0);
    chk("t1_sb", fwd_sel_b, 0);

    // ADD r3<-r1,r2 right after r1 producer, then SUB r4<-r3,r3
    alu(4'd3, 4'd1, 4'd2);
    tick();
    chk("d1p_sa", fwd_sel_a, 1);
    chk("d1p_sb", fwd_sel_b, 0);
    alu(4'd4, 4'd3, 4'd3);
    chk("d1_stall", stall, 0);
    tick();
    chk("d1_sa", fwd_sel_a, 1);
    chk("d1_sb", fwd_sel_b, 1);

    // one independent between
    alu(4'd3, 4'd10, 4'd11); tick();
    chk("p_sa", fwd_sel_a, 0);
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd4, 4'd3, 4'd3);   tick();
    chk("d2_sa", fwd_sel_a, 2);
    chk("d2_sb", fwd_sel_b, 2);

    // two between
    alu(4'd3, 4'd10, 4'd11); tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd4, 4'd3, 4'd3);   tick();
    chk("d3_sa", fwd_sel_a, 3);
    chk("d3_sb", fwd_sel_b, 3);

    // three between
    alu(4'd3, 4'd10, 4'd11); tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd4, 4'd3, 4'd3);   tick();
    chk("d4_sa", fwd_sel_a, 0);
    chk("d4_sb", fwd_sel_b, 0);
    chk("d4_exv", ex_valid, 1);

    // LOAD r5 <- [r12]; ADD r6 <- r5,r2
    drv(1'b1, 4'd12, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    alu(4'd6, 4'd5, 4'd2);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_exv", ex_valid, 0);
    chk("lu_bsa", fwd_sel_a, 0);
    chk("lu_bsb", fwd_sel_b, 0);
    chk("lu_cnt", stall_count, 1);
    alu(4'd6, 4'd5, 4'd2);
    chk("lu_stall2", stall, 0);
    tick();
    chk("lu_exv2", ex_valid, 1);
    chk("lu_sa", fwd_sel_a, 2);
    chk("lu_sb", fwd_sel_b, 0);
    chk("lu_cnt2", stall_count, 1);

    // same hazard with flush
    drv(1'b1, 4'd12, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", stall, 0);
    tick();
    chk("fl_exv", ex_valid, 0);
    chk("fl_cnt", stall_count, 1);

    // writes to r0 never forward
    alu(4'd0, 4'd12, 4'd12); tick();
    alu(4'd1, 4'd0, 4'd0);   tick();
    chk("r0_sa", fwd_sel_a, 0);
    chk("r0_sb", fwd_sel_b, 0);

    // unused source selects 00
    alu(4'd9, 4'd12, 4'd12); tick();
    drv(1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("un_sa", fwd_sel_a, 0);
    chk("un_sb", fwd_sel_b, 1);

    // r7 in both ex and mem: youngest wins
    alu(4'd7, 4'd12, 4'd12); tick();
    alu(4'd7, 4'd12, 4'd12); tick();
    alu(4'd1, 4'd7, 4'd7);   tick();
    chk("yg_sa", fwd_sel_a, 1);
    chk("yg_sb", fwd_sel_b, 1);

    // load already in mem: no stall, select 10
    drv(1'b1, 4'd12, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    alu(4'd8, 4'd12, 4'd12); tick();
    alu(4'd6, 4'd5, 4'd12);
    chk("lm_stall", stall, 0);
    tick();
    chk("lm_sa", fwd_sel_a, 2);
    chk("lm_sb", fwd_sel_b, 0);
    chk("lm_cnt", stall_count, 1);

    // chain of LOAD r5 <- [r5]: a stall every other cycle,
    // ~20 stalls on top of 1 saturates a 4-bit counter at 15
    for (int i = 0; i < 40; i++) begin
      drv(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("sat_cnt", stall_count, 15);

    // set up a live stall, then reset asynchronously inside it
    drv(1'b1, 4'd12, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    alu(4'd6, 4'd5, 4'd2);
    chk("ms_stall", stall, 1);
    chk("ms_cnt", stall_count, 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", stall_count, 0);
    chk("ar_sa", fwd_sel_a, 0);
    chk("ar_exv", ex_valid, 0);
    chk("ar_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // after release no producer survives
    alu(4'd6, 4'd5, 4'd2);
    chk("pr_stall", stall, 0);
    tick();
    chk("pr_exv", ex_valid, 1);
    chk("pr_sa", fwd_sel_a, 0);
    chk("pr_cnt", stall_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
